bin2bcd_seq: RTL and testbench

Iterative binary-to-BCD converter (shift-and-add-3 / double dabble) feeding the 8-digit seven-segment display driver. It accepts a 32-bit unsigned value on a start strobe and converts it over 32 shift cycles. It then presents eight packed BCD nibbles with a one-cycle chip-select pulse, so the display shows decimal instead of hex. Values above 99 999 999 produce the all-'E' overflow pattern.

---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bin2bcd_if.sv | 16 +
 rtl/bcd_add3.sv | 7 +
 rtl/bin2bcd_seq.sv | 89 ++++++++
 tb/tb_bin2bcd_seq.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int          DIGITS         = 8;   // digits presented to the display
  localparam int          BCD_INT_DIGITS = 10;  // enough for 4 294 967 295
  localparam int          BIN_W          = 32;
  localparam int          SHIFT_CYCLES   = 32;
  localparam logic [31:0] OVF_PATTERN    = 32'hEEEEEEEE;

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin2bcd_if;
  import bin2bcd_pkg::*;

  logic                  start;
  logic [BIN_W-1:0]      iBin;
  logic                  oBusy;
  logic                  oCs;
  logic [4*DIGITS-1:0]   oData;
  logic                  oOvf;

  modport master (output start, output iBin,
                  input  oBusy, input oCs, input oData, input oOvf);
  modport slave  (input  start, input iBin,
                  output oBusy, output oCs, output oData, output oOvf);
endinterface

// File: rtl/bcd_add3.sv
// Single-digit double-dabble adjust: digits of 5..15 get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 8-digit packed BCD converter (shift-and-add-3).
// One conversion takes 32 shift cycles plus one result cycle; overflow
// above 99 999 999 is flagged from the two extra internal digits.
module bin2bcd_seq
  import bin2bcd_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  bin2bcd_if.slave  bus
);

  state_e                                state_q, state_d;
  logic [4:0]                            count_q, count_d;
  logic [BIN_W-1:0]                      bin_q, bin_d;
  logic [BCD_INT_DIGITS-1:0][3:0]        bcd_q, bcd_d;
  logic [BCD_INT_DIGITS-1:0][3:0]        bcd_adj;
  logic                                  cs_q, cs_d;
  logic [4*DIGITS-1:0]                   data_q, data_d;
  logic                                  ovf_q, ovf_d;
  logic                                  ovf_now;

  // Per-digit adjust, no carry between digits.
  for (genvar g = 0; g < BCD_INT_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.d_i(bcd_q[g]), .d_o(bcd_adj[g]));
  end

  // Overflow is any nonzero digit above the displayed eight.
  assign ovf_now = (bcd_q[BCD_INT_DIGITS-1:DIGITS] != '0);

  // State, shift register and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cs_q    <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cs_q    <= cs_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath: load on accept, adjust+shift for 32 cycles, publish.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cs_d    = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.iBin;
          bcd_d   = '0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        count_d        = 5'(count_q + 5'd1);
        if (count_q == 5'(SHIFT_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        ovf_d   = ovf_now;
        data_d  = ovf_now ? OVF_PATTERN : bcd_q[DIGITS-1:0];
        cs_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.oBusy = (state_q != IDLE);
  assign bus.oCs   = cs_q;
  assign bus.oData = data_q;
  assign bus.oOvf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised and directed checks of bin2bcd_seq against a decimal reference model.
module tb_bin2bcd_seq;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  bin2bcd_if bus ();

  bin2bcd_seq dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division; too large -> all 'E'.
  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    longint unsigned n;
    logic [31:0]     r;
    n = longint'(v);
    r = '0;
    if (n > 64'd99999999) return 32'hEEEEEEEE;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return (v > 32'd99999999);
  endfunction

  // Start one conversion and wait (bounded) for the strobe.
  task automatic run_conv(input logic [31:0] v, output int lat, output logic [31:0] d,
                          output logic ovf, output logic busy_at_cs, output logic cs_next,
                          output logic busy_after_accept);
    @(negedge clk);
    bus.iBin  = v;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.iBin  = $urandom;
    busy_after_accept = bus.oBusy;
    lat = 0;
    while (!bus.oCs && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d          = bus.oData;
    ovf        = bus.oOvf;
    busy_at_cs = bus.oBusy;
    @(posedge clk);
    #1;
    cs_next = bus.oCs;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.iBin  = '0;
    #12;
    vectors++;
    if ({bus.oData, bus.oCs, bus.oBusy, bus.oOvf} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_state: got data=%h cs=%b busy=%b ovf=%b, want all 0",
               bus.oData, bus.oCs, bus.oBusy, bus.oOvf);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if ({bus.oData, bus.oCs, bus.oBusy, bus.oOvf} !== 35'd0) begin
        miscompares++;
        $display("FAIL idle_quiet: got data=%h cs=%b busy=%b ovf=%b, want all 0",
                 bus.oData, bus.oCs, bus.oBusy, bus.oOvf);
      end
    end
  endtask

  task automatic check_conv(input string name, input logic [31:0] v);
    int lat;
    logic [31:0] d;
    logic ovf, bcs, csn, bacc;
    run_conv(v, lat, d, ovf, bcs, csn, bacc);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, want 33 (v=%0d)", name, lat, v);
    end
    vectors++;
    if (d !== model_bcd(v) || ovf !== model_ovf(v)) begin
      miscompares++;
      $display("FAIL %s data: v=%0d got data=%h ovf=%b, want data=%h ovf=%b",
               name, v, d, ovf, model_bcd(v), model_ovf(v));
    end
    vectors++;
    if (bcs !== 1'b0 || csn !== 1'b0 || bacc !== 1'b1) begin
      miscompares++;
      $display("FAIL %s strobe: busy@cs=%b cs_next=%b busy_after_accept=%b, want 0 0 1",
               name, bcs, csn, bacc);
    end
  endtask

  task automatic test_directed();
    check_conv("nominal",  32'd12345678);
    check_conv("zero",     32'd0);
    check_conv("max_fit",  32'd99999999);
    check_conv("min_ovf",  32'd100000000);
    check_conv("all_ones", 32'hFFFFFFFF);
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) v = $urandom;
      else if (i % 3 == 1) v = $urandom_range(99999999, 0);
      else v = $urandom_range(9999, 0);
      check_conv("random", v);
    end
  endtask

  task automatic test_busy_drop();
    int pulses, pe;
    logic [31:0] pd;
    pulses = 0; pe = -1; pd = '0;
    @(negedge clk);
    bus.iBin  = 32'd42;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 75; e++) begin
      @(negedge clk);
      if (e == 10) begin
        bus.start = 1'b1;
        bus.iBin  = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.oCs) begin
        pulses++;
        pe = e;
        pd = bus.oData;
      end
    end
    vectors++;
    if (pulses !== 1 || pe !== 33) begin
      miscompares++;
      $display("FAIL busy_drop_strobe: got %0d pulses last at edge %0d, want 1 at 33", pulses, pe);
    end
    vectors++;
    if (pd !== 32'h00000042 || bus.oData !== 32'h00000042) begin
      miscompares++;
      $display("FAIL busy_drop_data: got %h (now %h), want 00000042", pd, bus.oData);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int edges[2];
    logic [31:0] datas[2];
    n = 0;
    @(negedge clk);
    bus.iBin  = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.iBin = 32'd6;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk);
      #1;
      if (e == 34) bus.start = 1'b0;
      if (bus.oCs) begin
        if (n < 2) begin
          edges[n] = e;
          datas[n] = bus.oData;
        end
        n++;
      end
    end
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d strobes, want 2", n);
    end else begin
      vectors++;
      if (edges[0] !== 33 || edges[1] !== 67) begin
        miscompares++;
        $display("FAIL b2b_timing: got edges %0d,%0d want 33,67", edges[0], edges[1]);
      end
      vectors++;
      if (datas[0] !== model_bcd(32'd5) || datas[1] !== model_bcd(32'd6)) begin
        miscompares++;
        $display("FAIL b2b_data: got %h,%h want %h,%h", datas[0], datas[1],
                 model_bcd(32'd5), model_bcd(32'd6));
      end
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    logic [31:0] v;
    pulses = 0;
    // Leave a nonzero result on the outputs first.
    check_conv("pre_abort", 32'd31337);
    @(negedge clk);
    bus.iBin  = 32'd87654321;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.oData, bus.oCs, bus.oBusy, bus.oOvf} !== 35'd0) begin
      miscompares++;
      $display("FAIL abort_async: got data=%h cs=%b busy=%b ovf=%b, want all 0",
               bus.oData, bus.oCs, bus.oBusy, bus.oOvf);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk);
      #1;
      if (bus.oCs || bus.oBusy) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d active cycles after reset, want 0", pulses);
    end
    v = $urandom;
    check_conv("post_abort", v);
    check_conv("post_abort2", 32'd12345678);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_drop();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
